// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Package : pcie_phy_pkg
//  Purpose : Shared symbol constants and types for the PHY transmit path.
//            K28.5 COM, K28.0 SKP and D0.0 logical idle byte codes, the
//            scheduler state encoding and the {byte, K-flag} symbol type.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pcie_phy_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  localparam logic [7:0] D0_0_IDLE = 8'h00;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_IDLE = 2'd1,
    S_DATA = 2'd2,
    S_SKP  = 2'd3
  } tx_sched_state_e;

  typedef struct packed {
    logic [7:0] sym;
    logic       k;
  } tx_sym_t;

endpackage
`default_nettype wire

// File: rtl/tx_skp_scheduler_timer.sv
`default_nettype none
// ============================================================================
//  Module  : skp_interval_timer
//  Purpose : Counts emitted symbols modulo INTERVAL and keeps a saturating
//            count of SKP ordered sets that are due but not yet sent.
//  Ports   : clk_i   in  clock
//            rst_i   in  asynchronous active-high reset
//            tick    in  a symbol is emitted this cycle
//            dec     in  an ordered set completes this cycle
//            clr     in  synchronous clear of counter and pending count
//            pend_nz out at least one ordered set is pending
//  Rev     : 1.0  initial release
// ============================================================================
module skp_interval_timer #(
  parameter int INTERVAL = 1180,
  parameter int PEND_W   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick,
  input  logic dec,
  input  logic clr,
  output logic pend_nz
);

  localparam int              c_CNT_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

  logic [c_CNT_W-1:0] r_cnt;
  logic [PEND_W-1:0]  r_pend;
  logic               w_expire;

  assign w_expire = tick && (r_cnt == c_CNT_W'(INTERVAL - 1));
  assign pend_nz  = |r_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      if (tick) begin
        r_cnt <= w_expire ? '0 : r_cnt + c_CNT_W'(1);
      end
      // An expiry coinciding with a completed ordered set cancels out.
      // An expiry while saturated is dropped.
      case ({w_expire, dec})
        2'b10: if (r_pend != c_PEND_MAX) r_pend <= r_pend + 1'b1;
        2'b01: if (r_pend != '0)         r_pend <= r_pend - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_skp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tx_skp_scheduler
//  Purpose : Picks one symbol per cycle for the 8b/10b encoder: packet data,
//            D0.0 logical idle, or a SKP ordered set (COM + SKP_LEN SKPs).
//            Ordered sets are scheduled every SKP_INTERVAL symbols and are
//            only inserted between packets.
//  Ports   : clk_i, rst_i (async, active-high)
//            en_i                link TX enable
//            data_valid_i/data_i/data_k_i/data_eop_i   upstream symbol
//            data_ready_o        upstream accept (combinational)
//            sym_o/sym_k_o/sym_valid_o   registered symbol to encoder
//            skp_sent_o          pulse with the COM of each ordered set
//            underrun_o          pulse when idle fills a packet gap
//  Rev     : 1.0  initial release
// ============================================================================
module tx_skp_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int PEND_W       = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  input  logic       data_k_i,
  input  logic       data_eop_i,
  output logic       data_ready_o,
  output logic [7:0] sym_o,
  output logic       sym_k_o,
  output logic       sym_valid_o,
  output logic       skp_sent_o,
  output logic       underrun_o
);

  localparam logic [1:0] c_IDX_LAST = 2'(SKP_LEN - 1);

  tx_sched_state_e r_state;
  logic [1:0]      r_skp_idx;
  tx_sym_t         r_sym;
  logic            r_sym_valid;
  logic            r_skp_sent;
  logic            r_underrun;

  logic w_pend_nz;
  logic w_ready;
  logic w_accept;
  logic w_tick;
  logic w_dec;
  logic w_idx_last;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = en_i && !w_pend_nz;
      S_DATA:  w_ready = en_i;
      default: w_ready = 1'b0;
    endcase
  end

  assign w_accept   = data_valid_i && w_ready;
  assign w_idx_last = (r_skp_idx == c_IDX_LAST);
  // Every enabled cycle outside S_OFF loads a valid symbol.
  assign w_tick     = en_i && (r_state != S_OFF);
  assign w_dec      = en_i && (r_state == S_SKP) && w_idx_last;

  skp_interval_timer #(
    .INTERVAL (SKP_INTERVAL),
    .PEND_W   (PEND_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tick    (w_tick),
    .dec     (w_dec),
    .clr     (!en_i),
    .pend_nz (w_pend_nz)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_OFF;
      r_skp_idx   <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_skp_sent  <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (!en_i) begin
      // Disable abandons any packet and truncates any ordered set.
      r_state     <= S_OFF;
      r_skp_idx   <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_skp_sent  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_sym_valid <= 1'b1;
      r_skp_sent  <= 1'b0;
      r_underrun  <= 1'b0;
      case (r_state)
        S_OFF: begin
          r_sym_valid <= 1'b0;
          r_sym       <= '0;
          r_state     <= S_IDLE;
        end
        S_IDLE: begin
          if (w_pend_nz) begin
            r_sym      <= tx_sym_t'{sym: K28_5_COM, k: 1'b1};
            r_skp_sent <= 1'b1;
            r_state    <= S_SKP;
          end else if (w_accept) begin
            r_sym <= tx_sym_t'{sym: data_i, k: data_k_i};
            if (!data_eop_i) r_state <= S_DATA;
          end else begin
            r_sym <= tx_sym_t'{sym: D0_0_IDLE, k: 1'b0};
          end
        end
        S_DATA: begin
          // Pending SKPs wait here; a packet is never split.
          if (w_accept) begin
            r_sym <= tx_sym_t'{sym: data_i, k: data_k_i};
            if (data_eop_i) r_state <= S_IDLE;
          end else begin
            r_sym      <= tx_sym_t'{sym: D0_0_IDLE, k: 1'b0};
            r_underrun <= 1'b1;
          end
        end
        S_SKP: begin
          r_sym <= tx_sym_t'{sym: K28_0_SKP, k: 1'b1};
          if (w_idx_last) begin
            r_skp_idx <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_skp_idx <= r_skp_idx + 2'd1;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign data_ready_o = w_ready;
  assign sym_o        = r_sym.sym;
  assign sym_k_o      = r_sym.k;
  assign sym_valid_o  = r_sym_valid;
  assign skp_sent_o   = r_skp_sent;
  assign underrun_o   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tx_skp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tx_skp_scheduler
//  Purpose : Directed bench for tx_skp_scheduler with SKP_INTERVAL=16,
//            SKP_LEN=3, PEND_W=2. Expected symbol streams are hand-derived
//            from the symbol counter position at each step.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_tx_skp_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       data_valid_i;
  logic [7:0] data_i;
  logic       data_k_i;
  logic       data_eop_i;
  logic       data_ready_o;
  logic [7:0] sym_o;
  logic       sym_k_o;
  logic       sym_valid_o;
  logic       skp_sent_o;
  logic       underrun_o;

  int checks = 0;
  int errors = 0;

  tx_skp_scheduler #(
    .SKP_INTERVAL (16),
    .SKP_LEN      (3),
    .PEND_W       (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_k_i     (data_k_i),
    .data_eop_i   (data_eop_i),
    .data_ready_o (data_ready_o),
    .sym_o        (sym_o),
    .sym_k_o      (sym_k_o),
    .sym_valid_o  (sym_valid_o),
    .skp_sent_o   (skp_sent_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic k,
                            input logic v, input logic sent, input logic und);
    chk({tag, ".sym"},   sym_o,       s);
    chk({tag, ".k"},     sym_k_o,     k);
    chk({tag, ".valid"}, sym_valid_o, v);
    chk({tag, ".skp"},   skp_sent_o,  sent);
    chk({tag, ".und"},   underrun_o,  und);
  endtask

  // Advance one clock and sample just after the active edge.
  task automatic cyc_chk(input string tag, input logic [7:0] s, input logic k,
                         input logic v, input logic sent, input logic und);
    @(posedge clk_i);
    #2;
    expect_out(tag, s, k, v, sent, und);
  endtask

  task automatic idle_n(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc_chk(tag, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic skp_set(input string tag);
    cyc_chk({tag, ".com"}, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc_chk({tag, ".skp"}, 8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Streams n consecutive bytes starting at 'first'; each must appear one
  // cycle after it is offered, with ready held high throughout.
  task automatic drive_pkt(input logic [7:0] first, input int n, input logic k_first,
                           input logic eop_last, input string tag);
    for (int i = 0; i < n; i++) begin
      data_valid_i = 1'b1;
      data_i       = first + 8'(i);
      data_k_i     = (i == 0) ? k_first : 1'b0;
      data_eop_i   = eop_last && (i == n - 1);
      #1;
      chk({tag, ".ready"}, data_ready_o, 1'b1);
      cyc_chk(tag, first + 8'(i), (i == 0) ? k_first : 1'b0, 1'b1, 1'b0, 1'b0);
    end
    data_valid_i = 1'b0;
    data_k_i     = 1'b0;
    data_eop_i   = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    en_i         = 1'b0;
    data_valid_i = 1'b0;
    data_i       = 8'h00;
    data_k_i     = 1'b0;
    data_eop_i   = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    #2;
    expect_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.ready", data_ready_o, 1'b0);
    rst_i = 1'b0;
    en_i  = 1'b1;

    // 1: idle stream with periodic ordered sets (period 16 symbols)
    cyc_chk("t1.off", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.ready_idle", data_ready_o, 1'b1);
    idle_n(16, "t1.idle16");
    chk("t1.ready_pend", data_ready_o, 1'b0);
    skp_set("t1.set1");
    idle_n(12, "t1.idle12");
    skp_set("t1.set2");

    // 2: 40-byte packet from cnt=4 crosses two expiries (pend=2); the
    //    first set's last SKP coincides with a third expiry, so three
    //    back-to-back sets follow eop.
    drive_pkt(8'h01, 40, 1'b0, 1'b1, "t2.pkt");
    #1;
    chk("t2.ready_after_eop", data_ready_o, 1'b0);
    skp_set("t2.setA");
    skp_set("t2.setB");
    skp_set("t2.setC");

    // 3: gap of 3 cycles mid-packet; expiry during the packet is deferred
    drive_pkt(8'hA1, 3, 1'b1, 1'b0, "t3.head");
    for (int i = 0; i < 3; i++) cyc_chk("t3.gap", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    drive_pkt(8'hA4, 3, 1'b0, 1'b1, "t3.tail");
    skp_set("t3.set");

    // 4: align cnt to 12, then 100-byte packet saturates pend at 3
    idle_n(7, "t4.align");
    drive_pkt(8'h30, 100, 1'b0, 1'b1, "t4.pkt");
    skp_set("t4.set1");
    skp_set("t4.set2");
    skp_set("t4.set3");
    #1;
    chk("t4.ready_drained", data_ready_o, 1'b1);

    // 5: disable during 2nd SKP, then re-enable
    idle_n(4, "t5.idle");
    cyc_chk("t5.com",  8'hBC, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc_chk("t5.skp1", 8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc_chk("t5.skp2", 8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    en_i = 1'b0;
    #1;
    chk("t5.ready_dis", data_ready_o, 1'b0);
    cyc_chk("t5.off1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc_chk("t5.off2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    en_i = 1'b1;
    cyc_chk("t5.wake", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5.ready_wake", data_ready_o, 1'b1);
    idle_n(16, "t5.idle16");
    skp_set("t5.set");

    // 6: asynchronous reset mid-packet
    drive_pkt(8'h50, 4, 1'b0, 1'b0, "t6.pkt");
    data_valid_i = 1'b1;
    data_i       = 8'h54;
    #1;
    rst_i = 1'b1;
    #1;
    expect_out("t6.async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.ready_rst", data_ready_o, 1'b0);
    data_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    cyc_chk("t6.off", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc_chk("t6.idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
